// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencer and its forwarding search.
package pipe_pkg;

   localparam int IF       = 0;
   localparam int ID       = 1;
   localparam int FWD_NONE = 0;

   // Register addresses are stored zero-extended so one struct serves any REGADDR <= RD_MAXW.
   localparam int RD_MAXW  = 8;

   typedef struct packed {
      logic [RD_MAXW-1:0] rd;
      logic               regwrite;
      logic               memread;
   } stage_meta_t;

   function automatic int fwdw(input int depth, input int ex_stage);
      return ($clog2(depth - ex_stage) < 1) ? 1 : $clog2(depth - ex_stage);
   endfunction

endpackage

// File: rtl/pipe_fwd_select.sv
// Nearest-producer priority search for one EX operand; index 0 of the producer
// vectors is the stage directly after EX.
module pipe_fwd_select
   import pipe_pkg::*;
#(
   parameter int NPROD    = 2,
   parameter int FWDW     = 2,
   parameter int ZERO_REG = 31
) (
   input  logic [RD_MAXW-1:0]            src,
   input  logic                          src_use,
   input  logic                          consumer_valid,
   input  logic [NPROD-1:0]              prod_en,
   input  logic [NPROD-1:0][RD_MAXW-1:0] prod_rd,
   output logic [FWDW-1:0]               sel
);

   always_comb begin
      sel = FWDW'(FWD_NONE);
      if (consumer_valid && src_use && (src != RD_MAXW'(ZERO_REG))) begin
         // Scan oldest to youngest so the nearest match is written last.
         for (int d = NPROD; d >= 1; d--) begin
            if (prod_en[d-1] && (prod_rd[d-1] == src)) begin
               sel = FWDW'(d);
            end
         end
      end
   end

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline control: per-stage valid/metadata tracking, load-use stall, branch flush
// and EX forwarding selects. PIPE_SEQUENCER_STATS_EN adds saturating event counters.
module pipe_sequencer
   import pipe_pkg::*;
#(
   parameter int DEPTH        = 5,
   parameter int EX_STAGE     = 2,
   parameter int BRANCH_STAGE = 4,
   parameter int REGADDR      = 5,
   parameter int ZERO_REG     = 31
`ifdef PIPE_SEQUENCER_STATS_EN
   ,
   parameter int CNTW         = 32
`endif
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                if_valid,
   input  logic [REGADDR-1:0]                  id_ra,
   input  logic [REGADDR-1:0]                  id_rb,
   input  logic                                id_ra_use,
   input  logic                                id_rb_use,
   input  logic [REGADDR-1:0]                  id_rd,
   input  logic                                id_regwrite,
   input  logic                                id_memread,
   input  logic                                branch_taken,
   output logic [DEPTH-1:0]                    stage_valid,
   output logic                                stall,
   output logic                                flush,
   output logic [fwdw(DEPTH, EX_STAGE)-1:0]    fwd_a,
   output logic [fwdw(DEPTH, EX_STAGE)-1:0]    fwd_b,
   output logic                                wb_regwrite
`ifdef PIPE_SEQUENCER_STATS_EN
   ,
   output logic [CNTW-1:0]                     stat_stalls,
   output logic [CNTW-1:0]                     stat_flushes,
   output logic [CNTW-1:0]                     stat_retired
`endif
);

   localparam int FWDW  = fwdw(DEPTH, EX_STAGE);
   localparam int NPROD = DEPTH - 1 - EX_STAGE;
   localparam logic [RD_MAXW-1:0] ZR = RD_MAXW'(ZERO_REG);

   logic [DEPTH-1:0]   valid_q;
   logic [DEPTH-1:0]   valid_src;
   logic [DEPTH-1:0]   valid_d;
   stage_meta_t        meta_q [DEPTH-1:EX_STAGE];
   logic [RD_MAXW-1:0] ex_ra_q;
   logic [RD_MAXW-1:0] ex_rb_q;
   logic               ex_ra_use_q;
   logic               ex_rb_use_q;

   logic [RD_MAXW-1:0] id_ra_x;
   logic [RD_MAXW-1:0] id_rb_x;
   logic [RD_MAXW-1:0] id_rd_x;
   logic               load_use;

   logic [NPROD-1:0]              prod_en;
   logic [NPROD-1:0][RD_MAXW-1:0] prod_rd;

   assign id_ra_x = RD_MAXW'(id_ra);
   assign id_rb_x = RD_MAXW'(id_rb);
   assign id_rd_x = RD_MAXW'(id_rd);

   always_comb begin
      load_use = valid_q[ID] && valid_q[EX_STAGE]
              && meta_q[EX_STAGE].memread && meta_q[EX_STAGE].regwrite
              && (meta_q[EX_STAGE].rd != ZR)
              && ((id_ra_use && (id_ra_x == meta_q[EX_STAGE].rd))
               || (id_rb_use && (id_rb_x == meta_q[EX_STAGE].rd)));
   end

   assign flush = branch_taken && valid_q[BRANCH_STAGE];
   assign stall = load_use && !flush;

   // Instructions younger than a taken branch are dropped before the shift, so
   // none of them survives into the branch's old slot either.
   always_comb begin
      valid_src = valid_q;
      if (flush) begin
         valid_src[BRANCH_STAGE-1:0] = '0;
      end
      valid_d = {valid_src[DEPTH-2:0], if_valid && !flush};
      if (stall) begin
         valid_d[IF]       = valid_q[IF];
         valid_d[ID]       = valid_q[ID];
         valid_d[EX_STAGE] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= '0;
         for (int k = EX_STAGE; k < DEPTH; k++) begin
            meta_q[k] <= '0;
         end
         ex_ra_q     <= '0;
         ex_rb_q     <= '0;
         ex_ra_use_q <= 1'b0;
         ex_rb_use_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (stall) begin
            meta_q[EX_STAGE] <= '0;
         end else begin
            meta_q[EX_STAGE].rd       <= id_rd_x;
            meta_q[EX_STAGE].regwrite <= id_regwrite;
            meta_q[EX_STAGE].memread  <= id_memread;
            ex_ra_q     <= id_ra_x;
            ex_rb_q     <= id_rb_x;
            ex_ra_use_q <= id_ra_use;
            ex_rb_use_q <= id_rb_use;
         end
         for (int k = EX_STAGE + 1; k < DEPTH; k++) begin
            meta_q[k] <= meta_q[k-1];
         end
      end
   end

   always_comb begin
      for (int d = 1; d <= NPROD; d++) begin
         prod_en[d-1] = valid_q[EX_STAGE+d] && meta_q[EX_STAGE+d].regwrite;
         prod_rd[d-1] = meta_q[EX_STAGE+d].rd;
      end
   end

   pipe_fwd_select #(
      .NPROD    (NPROD),
      .FWDW     (FWDW),
      .ZERO_REG (ZERO_REG)
   ) u_fwd_a (
      .src            (ex_ra_q),
      .src_use        (ex_ra_use_q),
      .consumer_valid (valid_q[EX_STAGE]),
      .prod_en        (prod_en),
      .prod_rd        (prod_rd),
      .sel            (fwd_a)
   );

   pipe_fwd_select #(
      .NPROD    (NPROD),
      .FWDW     (FWDW),
      .ZERO_REG (ZERO_REG)
   ) u_fwd_b (
      .src            (ex_rb_q),
      .src_use        (ex_rb_use_q),
      .consumer_valid (valid_q[EX_STAGE]),
      .prod_en        (prod_en),
      .prod_rd        (prod_rd),
      .sel            (fwd_b)
   );

   assign stage_valid = valid_q;
   assign wb_regwrite = valid_q[DEPTH-1] && meta_q[DEPTH-1].regwrite;

`ifdef PIPE_SEQUENCER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stalls  <= '0;
         stat_flushes <= '0;
         stat_retired <= '0;
      end else begin
         if (stall && (stat_stalls != '1)) begin
            stat_stalls <= stat_stalls + 1'b1;
         end
         if (flush && (stat_flushes != '1)) begin
            stat_flushes <= stat_flushes + 1'b1;
         end
         if (valid_q[DEPTH-1] && (stat_retired != '1)) begin
            stat_retired <= stat_retired + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Scoreboard bench for pipe_sequencer: an instruction-level pipeline model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_pipe_sequencer;

   localparam int DEPTH = 5;
   localparam int EXS   = 2;
   localparam int BRS   = 4;
   localparam int ZR    = 31;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       if_valid = 1'b0;
   logic [4:0] id_ra = '0, id_rb = '0, id_rd = '0;
   logic       id_ra_use = 1'b0, id_rb_use = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;
   logic       branch_taken = 1'b0;
   logic [4:0] stage_valid;
   logic       stall, flush, wb_regwrite;
   logic [1:0] fwd_a, fwd_b;
`ifdef PIPE_SEQUENCER_STATS_EN
   logic [31:0] stat_stalls, stat_flushes, stat_retired;
`endif

   always #5 clk = ~clk;

   pipe_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .if_valid     (if_valid),
      .id_ra        (id_ra),
      .id_rb        (id_rb),
      .id_ra_use    (id_ra_use),
      .id_rb_use    (id_rb_use),
      .id_rd        (id_rd),
      .id_regwrite  (id_regwrite),
      .id_memread   (id_memread),
      .branch_taken (branch_taken),
      .stage_valid  (stage_valid),
      .stall        (stall),
      .flush        (flush),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .wb_regwrite  (wb_regwrite)
`ifdef PIPE_SEQUENCER_STATS_EN
      ,
      .stat_stalls  (stat_stalls),
      .stat_flushes (stat_flushes),
      .stat_retired (stat_retired)
`endif
   );

   typedef struct {
      logic       v;
      logic [4:0] ra, rb, rd;
      logic       rau, rbu, rw, mr;
   } ins_t;

   typedef struct {
      logic [4:0]  sv;
      logic        st, fl, wbr;
      logic [1:0]  fa, fb;
      logic [31:0] cs, cf, cr;
   } exp_t;

   ins_t slot [DEPTH];
   exp_t sbq [$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] m_cs = '0, m_cf = '0, m_cr = '0;
   int   tot_stall, tot_flush;
   logic [3:0] fa_mask, fb_mask;

   function automatic ins_t junk();
      ins_t i;
      i.v = 1'b0;   i.ra = 5'($urandom); i.rb = 5'($urandom); i.rd = 5'($urandom);
      i.rau = 1'($urandom); i.rbu = 1'($urandom); i.rw = 1'($urandom); i.mr = 1'($urandom);
      return i;
   endfunction

   function automatic ins_t mk(input int rd, input bit rw, input bit mr,
                               input int ra, input bit rau, input int rb, input bit rbu);
      ins_t i = junk();
      i.v = 1'b1; i.rd = 5'(rd); i.rw = rw; i.mr = mr;
      i.ra = 5'(ra); i.rau = rau; i.rb = 5'(rb); i.rbu = rbu;
      return i;
   endfunction

   function automatic ins_t nop();
      ins_t i = junk();
      i.v = 1'b1; i.rw = 1'b0; i.mr = 1'b0; i.rau = 1'b0; i.rbu = 1'b0;
      return i;
   endfunction

   function automatic int rreg();
      int t = int'($urandom_range(0, 4));
      return (t == 4) ? ZR : t;
   endfunction

   function automatic ins_t rnd_ins();
      ins_t i = mk(rreg(), 1'($urandom), 1'($urandom), rreg(), 1'($urandom), rreg(), 1'($urandom));
      i.v = ($urandom_range(0, 9) < 8);
      return i;
   endfunction

   // Nearest older instruction (by distance behind EX) that writes the source register.
   function automatic logic [1:0] nearest(input logic [4:0] src, input logic en);
      if (!slot[EXS].v || !en || src == 5'(ZR)) return 2'd0;
      for (int d = 1; d < DEPTH - EXS; d++)
         if (slot[EXS+d].v && slot[EXS+d].rw && slot[EXS+d].rd == src) return 2'(d);
      return 2'd0;
   endfunction

   function automatic exp_t model_out(input logic br);
      exp_t e;
      ins_t ex  = slot[EXS];
      ins_t idi = slot[1];
      for (int k = 0; k < DEPTH; k++) e.sv[k] = slot[k].v;
      e.fl  = br && slot[BRS].v;
      e.st  = !e.fl && idi.v && ex.v && ex.mr && ex.rw && (ex.rd != 5'(ZR))
              && ((idi.rau && idi.ra == ex.rd) || (idi.rbu && idi.rb == ex.rd));
      e.fa  = nearest(ex.ra, ex.rau);
      e.fb  = nearest(ex.rb, ex.rbu);
      e.wbr = slot[DEPTH-1].v && slot[DEPTH-1].rw;
      e.cs  = m_cs;  e.cf = m_cf;  e.cr = m_cr;
      return e;
   endfunction

   function automatic void model_step(input exp_t e, input ins_t fetched);
      ins_t old [DEPTH];
      old = slot;
      if (e.fl) for (int k = 0; k < BRS; k++) old[k].v = 1'b0;
      for (int k = DEPTH - 1; k >= 1; k--) slot[k] = old[k-1];
      slot[0]   = fetched;
      slot[0].v = fetched.v && !e.fl;
      if (e.st) begin
         slot[0]   = old[0];
         slot[1]   = old[1];
         slot[EXS] = junk();
      end
      if (e.st && m_cs != 32'hFFFF_FFFF) m_cs = m_cs + 1;
      if (e.fl && m_cf != 32'hFFFF_FFFF) m_cf = m_cf + 1;
      if (e.sv[DEPTH-1] && m_cr != 32'hFFFF_FFFF) m_cr = m_cr + 1;
   endfunction

   function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_);
      n_cmp++;
      if (act !== exp_) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp_);
      end
   endfunction

   task automatic chk(input string nm, input int act, input int exp_);
      n_cmp++;
      if (act != exp_) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         cmp("stage_valid", 32'(stage_valid), 32'(e.sv));
         cmp("stall",       32'(stall),       32'(e.st));
         cmp("flush",       32'(flush),       32'(e.fl));
         cmp("fwd_a",       32'(fwd_a),       32'(e.fa));
         cmp("fwd_b",       32'(fwd_b),       32'(e.fb));
         cmp("wb_regwrite", 32'(wb_regwrite), 32'(e.wbr));
`ifdef PIPE_SEQUENCER_STATS_EN
         cmp("stat_stalls",  stat_stalls,  e.cs);
         cmp("stat_flushes", stat_flushes, e.cf);
         cmp("stat_retired", stat_retired, e.cr);
`endif
      end
   end

   // Called just after a posedge: drive one cycle, queue its expectation, advance the model.
   task automatic cycle(input ins_t f, input logic br, input logic r, output logic accepted);
      exp_t e;
      id_ra = slot[1].ra;  id_rb = slot[1].rb;  id_rd = slot[1].rd;
      id_ra_use = slot[1].rau;  id_rb_use = slot[1].rbu;
      id_regwrite = slot[1].rw; id_memread = slot[1].mr;
      if_valid = f.v;  branch_taken = br;  rst = r;
      e = model_out(br);
      sbq.push_back(e);
      #1;
      tot_stall += int'(stall);
      tot_flush += int'(flush);
      fa_mask[fwd_a] = 1'b1;
      fb_mask[fwd_b] = 1'b1;
      @(posedge clk);
      #1;
      if (r) begin
         for (int k = 0; k < DEPTH; k++) slot[k] = junk();
         m_cs = '0;  m_cf = '0;  m_cr = '0;
      end else begin
         model_step(e, f);
      end
      accepted = !e.st;
   endtask

   task automatic clr_obs();
      tot_stall = 0;  tot_flush = 0;  fa_mask = '0;  fb_mask = '0;
   endtask

   task automatic do_reset();
      logic acc;
      cycle(junk(), 1'b0, 1'b1, acc);
      clr_obs();
   endtask

   task automatic run(input ins_t prog [$], input int drain);
      logic acc;
      int   guard = 0;
      while (prog.size() > 0 && guard < 200) begin
         cycle(prog[0], 1'b0, 1'b0, acc);
         if (acc) void'(prog.pop_front());
         guard++;
      end
      if (prog.size() > 0) begin
         n_cmp++;  n_bad++;
         $display("FAIL run_guard: %0d instructions never accepted, expected 0", prog.size());
      end
      repeat (drain) cycle(junk(), 1'b0, 1'b0, acc);
   endtask

   initial begin
      ins_t p [$];
      logic acc;

      for (int k = 0; k < DEPTH; k++) slot[k] = junk();
      clr_obs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Fill with independent instructions.
      do_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(nop(), 1'b0, 1'b0, acc);
         chk("fill_stage_valid", int'(stage_valid), (1 << i) - 1);
      end
      chk("fill_no_stall", tot_stall, 0);
      chk("fill_no_flush", tot_flush, 0);
      chk("fill_fwd_a", int'(fa_mask), 1);

      // Load X3 then reader of X3.
      do_reset();
      p = '{mk(3, 1, 1, 0, 0, 0, 0), mk(9, 1, 0, 3, 1, 0, 0)};
      run(p, 6);
      chk("ldu_one_stall", tot_stall, 1);
      chk("ldu_fwd_a_2",   int'(fa_mask), 5);

      // ADD X5 then SUB reading X5 as rb; then with a spacer.
      do_reset();
      p = '{mk(5, 1, 0, 0, 0, 0, 0), mk(6, 1, 0, 0, 0, 5, 1)};
      run(p, 6);
      chk("add_fwd_b_1", int'(fb_mask), 3);
      chk("add_no_stall", tot_stall, 0);
      do_reset();
      p = '{mk(5, 1, 0, 0, 0, 0, 0), nop(), mk(6, 1, 0, 0, 0, 5, 1)};
      run(p, 6);
      chk("add_fwd_b_2", int'(fb_mask), 5);

      // Two writers of X7: nearest wins; XZR never forwards or stalls.
      do_reset();
      p = '{mk(7, 1, 0, 0, 0, 0, 0), mk(7, 1, 0, 0, 0, 0, 0), mk(8, 1, 0, 7, 1, 0, 0)};
      run(p, 6);
      chk("nearest_fwd_a_1", int'(fa_mask), 3);
      do_reset();
      p = '{mk(31, 1, 0, 0, 0, 0, 0), mk(31, 1, 1, 0, 0, 0, 0), mk(8, 1, 0, 31, 1, 31, 1)};
      run(p, 6);
      chk("xzr_fwd_a", int'(fa_mask), 1);
      chk("xzr_fwd_b", int'(fb_mask), 1);
      chk("xzr_no_stall", tot_stall, 0);

      // Taken branch with stage 4 valid, then with stage 4 empty.
      do_reset();
      p = '{nop(), nop(), nop(), nop(), nop()};
      run(p, 0);
      clr_obs();
      cycle(nop(), 1'b1, 1'b0, acc);
      chk("flush_seen", tot_flush, 1);
      chk("flush_squash", int'(stage_valid[3:0]), 0);
      do_reset();
      cycle(nop(), 1'b1, 1'b0, acc);
      chk("no_flush_empty", tot_flush, 0);

      // Flush coinciding with a load-use.
      do_reset();
      p = '{nop(), nop(), mk(3, 1, 1, 0, 0, 0, 0), mk(9, 1, 0, 3, 1, 0, 0), nop()};
      run(p, 0);
      clr_obs();
      cycle(nop(), 1'b1, 1'b0, acc);
      chk("flush_beats_stall_st", tot_stall, 0);
      chk("flush_beats_stall_fl", tot_flush, 1);

      // Reset with a full pipe of writers.
      do_reset();
      p = '{mk(1, 1, 0, 0, 0, 0, 0), mk(2, 1, 0, 1, 1, 0, 0), mk(1, 1, 0, 2, 1, 1, 1),
            mk(2, 1, 0, 1, 1, 2, 1), mk(3, 1, 0, 2, 1, 1, 1)};
      run(p, 0);
      cycle(nop(), 1'b0, 1'b1, acc);
      chk("rst_stage_valid", int'(stage_valid), 0);
      chk("rst_stall",       int'(stall), 0);
      chk("rst_flush",       int'(flush), 0);
      chk("rst_fwd_a",       int'(fwd_a), 0);
      chk("rst_fwd_b",       int'(fwd_b), 0);
      chk("rst_wb_regwrite", int'(wb_regwrite), 0);
`ifdef PIPE_SEQUENCER_STATS_EN
      chk("rst_stat_stalls",  int'(stat_stalls), 0);
      chk("rst_stat_flushes", int'(stat_flushes), 0);
      chk("rst_stat_retired", int'(stat_retired), 0);
`endif

      // Randomized traffic with dense register reuse.
      for (int n = 0; n < 800; n++) begin
         cycle(rnd_ins(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0), acc);
      end
      rst = 1'b0;

      for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         n_cmp++;  n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
- Parametrised pipeline control block for the LEGv8 pipelined core.
- Tracks per-stage valid bits and destination metadata, so no stage counter is needed and no garbage appears after reset.
- Generates load-use stalls, branch flushes and nearest-producer forwarding selects for any pipeline depth.
- Sits beside the pipeline registers. Drives their hold/bubble controls, the PC hold and the EX operand muxes.

Parameters:
- DEPTH, 5, number of stages; index 0 = IF, 1 = ID, DEPTH-1 = WB; legal DEPTH >= 4.
- EX_STAGE, 2, index of the stage whose operands are forwarded; legal 2 <= EX_STAGE <= DEPTH-2.
- BRANCH_STAGE, 4, stage where a branch is resolved; legal EX_STAGE <= BRANCH_STAGE <= DEPTH-1.
- REGADDR, 5, register address width.
- ZERO_REG, 31, register that never creates a hazard or a forward (XZR).
- CNTW, 32, statistics counter width (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  IF holds a real instruction
- id_ra  in  REGADDR  first source of the instruction in ID
- id_rb  in  REGADDR  second source of the instruction in ID
- id_ra_use  in  1  id_ra is actually read
- id_rb_use  in  1  id_rb is actually read
- id_rd  in  REGADDR  destination of the instruction in ID
- id_regwrite  in  1  the instruction in ID writes id_rd
- id_memread  in  1  the instruction in ID is a load
- branch_taken  in  1  branch at BRANCH_STAGE is taken; ignored unless that stage is valid
- stage_valid  out  DEPTH  per-stage valid bits
- stall  out  1  hold PC and IF/ID; bubble into EX
- flush  out  1  squash stages 0..BRANCH_STAGE-1
- fwd_a  out  FWDW  forwarding select for EX operand A; FWDW = clog2(DEPTH-EX_STAGE)
- fwd_b  out  FWDW  forwarding select for EX operand B
- wb_regwrite  out  1  stage_valid[DEPTH-1] AND that stage's regwrite

Behaviour:
- Reset (rst=1 at posedge): clear all stage_valid bits and all metadata. Outputs then read stall=0, flush=0, fwd_a=fwd_b=0, wb_regwrite=0. Reset overrides every other event.
- Metadata per stage k >= EX_STAGE: rd, regwrite, memread. EX additionally holds ra, rb, ra_use, rb_use. ID fields are captured into the EX slot when the pipe advances.
- Normal advance: slot k <= slot k-1 for k >= 1; stage_valid[0] <= if_valid.
- stall (combinational) is asserted when all of the following hold:
  - stage_valid[1] and stage_valid[EX_STAGE] are both set;
  - the EX slot has memread and regwrite set;
  - EX rd != ZERO_REG;
  - EX rd matches (id_ra with id_ra_use) or (id_rb with id_rb_use).
- On stall: slots 0 and 1 hold; the EX slot loads a bubble (valid=0, regwrite=0, memread=0); slots > EX_STAGE advance normally. Latency is exactly one bubble per load-use.
- flush (combinational) = branch_taken AND stage_valid[BRANCH_STAGE].
- On flush: next cycle stage_valid[0..BRANCH_STAGE-1] = 0. The branch instruction itself advances (it retires if BRANCH_STAGE = DEPTH-1). stall is forced to 0, so flush beats stall.
- Forwarding (combinational) for operand A:
  - fwd_a = smallest d in 1..DEPTH-1-EX_STAGE such that slot EX_STAGE+d is valid with regwrite, and its rd == EX ra.
  - Also requires EX ra_use, EX ra != ZERO_REG and stage_valid[EX_STAGE].
  - Otherwise fwd_a = 0 (use the register file value). The nearest producer wins.
  - fwd_b is the same rule on rb.
- Slots that are invalid never match for stall, forwarding or wb_regwrite.

Optional Feature:
- Macro: PIPE_SEQUENCER_STATS_EN.
- When defined, add three CNTW-bit outputs, all cleared by rst and saturating at all-ones:
  - stat_stalls: increments each cycle stall=1.
  - stat_flushes: increments each cycle flush=1.
  - stat_retired: increments each cycle stage_valid[DEPTH-1]=1.
- When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package pipe_pkg holds:
  - the stage-metadata struct (rd, regwrite, memread);
  - the stage index constants IF=0, ID=1;
  - the FWD_NONE=0 encoding;
  - the clog2-based FWDW function.
- One sub-module, pipe_fwd_select: a combinational nearest-producer priority search, instantiated once per operand.

Test Plan:
- Reset, then if_valid=1 held: stage_valid steps 00001→00011→00111→01111→11111 over 5 cycles. stall, flush and fwd stay 0.
- Load to X3, immediately followed by an instruction reading X3 (id_ra=3, id_ra_use=1): stall=1 for exactly one cycle. EX gets a bubble and fwd_a=2 on the next EX cycle.
- ADD to X5, then SUB reading X5 as rb: fwd_b=1 with no stall. Insert one independent instruction between them: fwd_b=2.
- Two writers to X7 in consecutive stages MEM and WB: fwd_a=1, so the nearest producer wins. With rd=31: fwd_a=0 and no stall.
- branch_taken=1 with stage_valid[4]=1: flush=1, and stage_valid[3:0]=0 next cycle. branch_taken=1 with stage_valid[4]=0: no flush. Flush coinciding with a load-use: stall=0.
- rst asserted mid-stream with a full pipe: next cycle all outputs 0. With PIPE_SEQUENCER_STATS_EN defined, the counters also read 0.
